// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, default timing and mouse command bytes.
package ps2_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_REQ,
    S_DATA,
    S_PARITY,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } ps2_tx_state_e;

  // 50 MHz defaults: 120 us inhibit, 15 ms request window, 2 ms bit gap
  localparam int unsigned DEF_INHIBIT_CYCLES = 6000;
  localparam int unsigned DEF_REQ_TIMEOUT    = 750000;
  localparam int unsigned DEF_BIT_TIMEOUT    = 100000;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a device-clock falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_ck,
  input  logic i_dt,
  output logic o_ck_s,
  output logic o_dt_s,
  output logic o_fall_c
);

  logic [1:0] r_ck_sync;
  logic [1:0] r_dt_sync;
  logic       r_ck_prev;

  // Reset to the idle-high level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ck_sync <= 2'b11;
      r_dt_sync <= 2'b11;
      r_ck_prev <= 1'b1;
    end else begin
      r_ck_sync <= {r_ck_sync[0], i_ck};
      r_dt_sync <= {r_dt_sync[0], i_dt};
      r_ck_prev <= r_ck_sync[1];
    end
  end

  assign o_ck_s   = r_ck_sync[1];
  assign o_dt_s   = r_dt_sync[1];
  assign o_fall_c = r_ck_prev & ~r_ck_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, start, 8 data bits LSB first, odd parity, stop, ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned REQ_TIMEOUT    = DEF_REQ_TIMEOUT,
  parameter int unsigned BIT_TIMEOUT    = DEF_BIT_TIMEOUT
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_error,
  inout  wire        ps2ck,
  inout  wire        ps2dt
);

  localparam int unsigned MAX_WAIT = max_u(max_u(INHIBIT_CYCLES, REQ_TIMEOUT), BIT_TIMEOUT);
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  ps2_tx_state_e    r_state, w_state_next;
  logic [7:0]       r_data, w_data_next;
  logic             r_parity, w_parity_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next, w_bit_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_ack, w_ack_next;
  logic             r_ck_low, w_ck_low_next;
  logic             r_dt_low, w_dt_low_next;
  logic             r_tx_ready, r_busy, r_done, r_ack_ok, r_error;
  logic             w_ck_s, w_dt_s, w_fall_c;
  logic             w_accept_c, w_bit_to_c, w_timed_c;

  ps2_line_sync u_sync (
    .clk      (CLOCK),
    .reset    (reset),
    .i_ck     (ps2ck),
    .i_dt     (ps2dt),
    .o_ck_s   (w_ck_s),
    .o_dt_s   (w_dt_s),
    .o_fall_c (w_fall_c)
  );

  // Open-drain pads: only ever pull low or float
  assign ps2ck = r_ck_low ? 1'b0 : 1'bz;
  assign ps2dt = r_dt_low ? 1'b0 : 1'bz;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= '0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_ck_low   <= 1'b0;
      r_dt_low   <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_ok   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_parity   <= w_parity_next;
      r_bit_idx  <= w_bit_idx_next;
      r_cnt      <= w_cnt_next;
      r_ack      <= w_ack_next;
      r_ck_low   <= w_ck_low_next;
      r_dt_low   <= w_dt_low_next;
      r_tx_ready <= (w_state_next == S_IDLE);
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= (w_state_next == S_DONE) || (w_state_next == S_ERR);
      r_ack_ok   <= (w_state_next == S_DONE) && r_ack;
      r_error    <= (w_state_next == S_ERR) || ((w_state_next == S_DONE) && !r_ack);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_data_next    = r_data;
    w_parity_next  = r_parity;
    w_bit_idx_next = r_bit_idx;
    w_ack_next     = r_ack;
    w_ck_low_next  = r_ck_low;
    w_dt_low_next  = r_dt_low;
    w_cnt_next     = r_cnt + CNT_W'(1);
    w_bit_inc      = r_bit_idx + 3'd1;
    w_accept_c     = tx_valid && r_tx_ready;
    w_bit_to_c     = (r_cnt == CNT_W'(BIT_TIMEOUT - 1));
    w_timed_c      = (r_state == S_DATA) || (r_state == S_PARITY) ||
                     (r_state == S_ACK)  || (r_state == S_WAIT_IDLE);

    case (r_state)
      S_IDLE: begin
        if (w_accept_c) begin
          w_state_next  = S_INHIBIT;
          w_data_next   = tx_data;
          w_parity_next = ~^tx_data;
          w_ck_low_next = 1'b1;
          w_dt_low_next = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          w_state_next  = S_START;
          w_dt_low_next = 1'b1;
        end
      end
      S_START: begin
        w_state_next  = S_REQ;
        w_ck_low_next = 1'b0;
      end
      S_REQ: begin
        if (w_fall_c) begin
          w_state_next   = S_DATA;
          w_bit_idx_next = '0;
          w_dt_low_next  = ~r_data[0];
        end else if (r_cnt == CNT_W'(REQ_TIMEOUT - 1)) begin
          w_state_next = S_ERR;
        end
      end
      // Bit counter tracks the bit currently on the line; its successor goes out on each fall
      S_DATA: begin
        if (w_fall_c) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next  = S_PARITY;
            w_dt_low_next = ~r_parity;
          end else begin
            w_bit_idx_next = w_bit_inc;
            w_dt_low_next  = ~r_data[w_bit_inc];
          end
        end else if (w_bit_to_c) begin
          w_state_next = S_ERR;
        end
      end
      S_PARITY: begin
        if (w_fall_c) begin
          w_state_next  = S_ACK;
          w_dt_low_next = 1'b0;
        end else if (w_bit_to_c) begin
          w_state_next = S_ERR;
        end
      end
      S_ACK: begin
        if (w_fall_c) begin
          w_state_next = S_WAIT_IDLE;
          w_ack_next   = ~w_dt_s;
        end else if (w_bit_to_c) begin
          w_state_next = S_ERR;
        end
      end
      S_WAIT_IDLE: begin
        if (w_ck_s && w_dt_s) begin
          w_state_next = S_DONE;
        end else if (w_bit_to_c) begin
          w_state_next = S_ERR;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    if (w_state_next == S_ERR) begin
      w_ck_low_next = 1'b0;
      w_dt_low_next = 1'b0;
    end

    if ((r_state == S_IDLE) || (w_state_next != r_state) || (w_fall_c && w_timed_c)) begin
      w_cnt_next = '0;
    end
  end

  assign tx_ready  = r_tx_ready;
  assign busy      = r_busy;
  assign tx_done   = r_done;
  assign tx_ack_ok = r_ack_ok;
  assign tx_error  = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device clocking the host frame.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH    = 60;
  localparam int unsigned REQ_TO = 400;
  localparam int unsigned BIT_TO = 150;
  localparam int          HALF   = 40;

  logic       CLOCK = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, tx_done, tx_ack_ok, tx_error;
  wire        ps2ck, ps2dt;
  logic       dev_ck_low, dev_dt_low;

  int   n_chk    = 0;
  int   n_err    = 0;
  int   n_done   = 0;
  int   n_double = 0;
  logic prev_done = 1'b0;

  assign ps2ck = dev_ck_low ? 1'b0 : 1'bz;
  assign ps2dt = dev_dt_low ? 1'b0 : 1'bz;
  pullup (ps2ck);
  pullup (ps2dt);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_TIMEOUT    (REQ_TO),
    .BIT_TIMEOUT    (BIT_TO)
  ) dut (
    .CLOCK     (CLOCK),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_ack_ok (tx_ack_ok),
    .tx_error  (tx_error),
    .ps2ck     (ps2ck),
    .ps2dt     (ps2dt)
  );

  always #10 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (tx_done === 1'b1) begin
      n_done = n_done + 1;
      if (prev_done === 1'b1) n_double = n_double + 1;
    end
    prev_done = tx_done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLOCK);
    tx_valid = 1'b0;
  endtask

  // Counts clock-only-low and both-low cycles until the host releases ps2ck
  task automatic watch_request(output int n_inh, output int n_both, output bit ok);
    n_inh  = 0;
    n_both = 0;
    ok     = 1'b0;
    for (int i = 0; i < 50 && ps2ck !== 1'b0; i++) @(negedge CLOCK);
    if (ps2ck !== 1'b0) return;
    for (int i = 0; i < int'(INH) * 2 + 20 && ps2ck === 1'b0; i++) begin
      if (ps2dt === 1'b0) n_both++;
      else n_inh++;
      @(negedge CLOCK);
    end
    ok = (ps2ck === 1'b1);
  endtask

  // Device samples each bit just before its falling edge; optionally pulls data low for ACK
  task automatic dev_run(input int n_falls, input bit ack_low, output logic [10:0] bits);
    bits = '0;
    for (int n = 0; n < n_falls; n++) begin
      repeat (HALF) @(negedge CLOCK);
      bits[n] = ps2dt;
      if (n == 10 && ack_low) begin
        dev_dt_low = 1'b1;
        repeat (5) @(negedge CLOCK);
      end
      dev_ck_low = 1'b1;
      repeat (HALF) @(negedge CLOCK);
      dev_ck_low = 1'b0;
      if (n == 10) dev_dt_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (tx_done !== 1'b1 && cycles < budget) begin
      @(negedge CLOCK);
      cycles++;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input logic par, input bit ack_low);
    int          n_inh, n_both, cyc;
    bit          ok;
    logic [10:0] bits;
    send(d);
    check_eq({tag, "_ck_low_after_accept"}, ps2ck, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_ready_low"}, tx_ready, 1'b0);
    watch_request(n_inh, n_both, ok);
    check_eq({tag, "_inhibit_cycles"}, n_inh, INH);
    check_eq({tag, "_start_cycles"}, n_both, 1);
    check_eq({tag, "_ck_released"}, ok, 1'b1);
    dev_run(11, ack_low, bits);
    check_eq({tag, "_frame"}, bits, {1'b1, par, d, 1'b0});
    wait_done(int'(BIT_TO), cyc);
    check_eq({tag, "_done"}, tx_done, 1'b1);
    check_eq({tag, "_ack_ok"}, tx_ack_ok, ack_low);
    check_eq({tag, "_error"}, tx_error, !ack_low);
    @(negedge CLOCK);
    check_eq({tag, "_ready_after"}, tx_ready, 1'b1);
    check_eq({tag, "_busy_after"}, busy, 1'b0);
    check_eq({tag, "_done_one_cycle"}, tx_done, 1'b0);
  endtask

  initial begin
    int          n_inh, n_both, cyc, done0;
    bit          ok;
    logic [10:0] bits;

    reset      = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    dev_ck_low = 1'b0;
    dev_dt_low = 1'b0;
    repeat (3) @(negedge CLOCK);
    check_eq("rst_ready", tx_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", tx_done, 1'b0);
    check_eq("rst_ack_ok", tx_ack_ok, 1'b0);
    check_eq("rst_error", tx_error, 1'b0);
    check_eq("rst_ck_z", ps2ck, 1'b1);
    check_eq("rst_dt_z", ps2dt, 1'b1);
    reset = 1'b0;
    @(negedge CLOCK);
    check_eq("ready_after_rst", tx_ready, 1'b1);

    run_xfer("f4", CMD_ENABLE, 1'b0, 1'b1);
    run_xfer("ff", CMD_RESET, 1'b1, 1'b1);

    // Device never clocks: request window expires
    send(CMD_RESET);
    watch_request(n_inh, n_both, ok);
    check_eq("reqto_released", ok, 1'b1);
    wait_done(int'(REQ_TO) + 50, cyc);
    check_eq("reqto_done", tx_done, 1'b1);
    check_eq("reqto_cycles", cyc, REQ_TO);
    check_eq("reqto_error", tx_error, 1'b1);
    check_eq("reqto_ack_ok", tx_ack_ok, 1'b0);
    check_eq("reqto_ck_z", ps2ck, 1'b1);
    check_eq("reqto_dt_z", ps2dt, 1'b1);
    @(negedge CLOCK);
    check_eq("reqto_ready_next", tx_ready, 1'b1);

    run_xfer("nack", CMD_SET_RATE, 1'b1, 1'b0);

    // Reset while data bit 4 is on the line
    done0 = n_done;
    send(8'h00);
    watch_request(n_inh, n_both, ok);
    check_eq("rstmid_released", ok, 1'b1);
    dev_run(5, 1'b0, bits);
    check_eq("rstmid_bits", bits[4:0], 5'b00000);
    check_eq("rstmid_d4_driven", ps2dt, 1'b0);
    reset = 1'b1;
    @(negedge CLOCK);
    check_eq("rstmid_ck_z", ps2ck, 1'b1);
    check_eq("rstmid_dt_z", ps2dt, 1'b1);
    check_eq("rstmid_busy", busy, 1'b0);
    check_eq("rstmid_ready", tx_ready, 1'b0);
    check_eq("rstmid_done", tx_done, 1'b0);
    reset = 1'b0;
    @(negedge CLOCK);
    check_eq("rstmid_ready_after", tx_ready, 1'b1);
    repeat (3 * BIT_TO) @(negedge CLOCK);
    check_eq("rstmid_no_done", n_done, done0);

    run_xfer("f3", CMD_SET_RATE, 1'b1, 1'b1);

    // tx_valid held through a transaction
    done0    = n_done;
    tx_data  = CMD_ENABLE;
    tx_valid = 1'b1;
    @(negedge CLOCK);
    check_eq("hold_acc1_ck", ps2ck, 1'b0);
    tx_data = CMD_RESET;
    watch_request(n_inh, n_both, ok);
    check_eq("hold1_released", ok, 1'b1);
    dev_run(11, 1'b1, bits);
    check_eq("hold1_frame", bits, {1'b1, 1'b0, CMD_ENABLE, 1'b0});
    wait_done(int'(BIT_TO), cyc);
    check_eq("hold1_done", tx_done, 1'b1);
    check_eq("hold1_ready_in_done", tx_ready, 1'b0);
    @(negedge CLOCK);
    check_eq("hold_gap_ready", tx_ready, 1'b1);
    check_eq("hold_gap_busy", busy, 1'b0);
    check_eq("hold_gap_ck", ps2ck, 1'b1);
    @(negedge CLOCK);
    check_eq("hold_acc2_busy", busy, 1'b1);
    check_eq("hold_acc2_ready", tx_ready, 1'b0);
    check_eq("hold_acc2_ck", ps2ck, 1'b0);
    tx_valid = 1'b0;
    watch_request(n_inh, n_both, ok);
    check_eq("hold2_released", ok, 1'b1);
    dev_run(11, 1'b1, bits);
    check_eq("hold2_frame", bits, {1'b1, 1'b1, CMD_RESET, 1'b0});
    wait_done(int'(BIT_TO), cyc);
    check_eq("hold2_done", tx_done, 1'b1);
    check_eq("hold2_ack_ok", tx_ack_ok, 1'b1);
    @(negedge CLOCK);
    check_eq("hold2_ready_after", tx_ready, 1'b1);
    check_eq("hold_done_count", n_done - done0, 2);

    check_eq("total_done_count", n_done, 7);
    check_eq("done_single_cycle", n_double, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 command transmitter. It sends one command byte to the mouse, such as 0xFF reset, 0xF4 enable reporting or 0xF3 set sample rate. It implements the full host-request sequence: inhibit the clock, send the start bit, shift data LSB first on device clocks, add the odd parity bit, release for the stop bit, then sample the device's line-level ACK bit. It shares the open-drain `ps2ck`/`ps2dt` pins with the mouse receive path, and `busy` gates that path while a command is in flight.

## Interface
- `INHIBIT_CYCLES`, default 6000: clock-low inhibit length in `CLOCK` cycles (120 µs at 50 MHz).
- `REQ_TIMEOUT`, default 750000: maximum wait for the first device falling edge after the clock is released (15 ms).
- `BIT_TIMEOUT`, default 100000: maximum gap between consecutive device falling edges, and maximum wait for idle (2 ms).
- `CLOCK` input, 1 bit: system clock, 50 MHz. This is the only clock.
- `reset` input, 1 bit: synchronous, active-high.
- `tx_data` input, 8 bits: command byte, captured on acceptance.
- `tx_valid` input, 1 bit: command request.
- `tx_ready` output, 1 bit: high only in IDLE. A command is accepted when `tx_valid && tx_ready`.
- `busy` output, 1 bit: high from acceptance until `tx_done`.
- `tx_done` output, 1 bit: one-cycle pulse at the end of a transaction.
- `tx_ack_ok` output, 1 bit: valid with `tx_done`. It is 1 when the ACK bit was sampled low and no timeout occurred.
- `tx_error` output, 1 bit: valid with `tx_done`. It is 1 on timeout or NACK.
- `ps2ck` inout, 1 bit: open-drain. Drives 0 or Z, never 1.
- `ps2dt` inout, 1 bit: open-drain. Drives 0 or Z, never 1.

## Operation
- Line inputs pass through a 2-FF synchronizer. A device falling edge (`fall`) is sync-prev=1 and sync-now=0.
- The FSM has the following states:
  - **IDLE**: both lines Z, `tx_ready`=1. On acceptance, latch `tx_data` and compute parity = `~^tx_data` (odd parity), then go to INHIBIT.
  - **INHIBIT**: `ps2ck`=0, `ps2dt`=Z for exactly `INHIBIT_CYCLES` cycles, then go to START.
  - **START**: `ps2ck`=0 and `ps2dt`=0 for exactly 1 cycle, then go to REQ.
  - **REQ**: `ps2ck`=Z, `ps2dt`=0 (the start bit).
    - On `fall`: drive d0 and go to DATA.
    - After `REQ_TIMEOUT` cycles with no `fall`: go to ERR.
  - **DATA**: a bit counter of 0..7 is in use. Each `fall` drives the next bit (d1..d7). The `fall` after d7 drives parity and moves to PARITY.
  - **PARITY**: on `fall`, release `ps2dt` to Z (the stop bit) and go to ACK.
  - **ACK**: the next `fall` samples synchronized `ps2dt`.
    - Sampled 0: go to WAIT_IDLE with ack=1.
    - Sampled 1: go to WAIT_IDLE with ack=0.
  - **WAIT_IDLE**: wait until both synchronized lines are 1, then go to DONE.
  - **DONE**: pulse `tx_done` with `tx_ack_ok`=ack and `tx_error`=~ack, then go to IDLE.
  - **ERR**: release both lines, pulse `tx_done` with `tx_error`=1 and `tx_ack_ok`=0, then go to IDLE.
- Any gap longer than `BIT_TIMEOUT` with no `fall` goes to ERR. This applies in DATA, PARITY and ACK, and also to WAIT_IDLE not reaching idle. The timeout counter is zeroed on every `fall` and on every state entry.
- `tx_valid` is ignored while `busy`. There is no queueing.
- Device traffic present at acceptance is overridden by the inhibit. Any partial byte is the receiver's problem, gated by `busy`.
- The device's 0xFA response byte arrives through the receive path, not through this block.

## Timing
- Reset values, for the cycle `reset` is high: state IDLE, both lines Z, and `busy`, `tx_done`, `tx_ack_ok`, `tx_error` all 0.
- `tx_ready` is 0 while `reset` is high and 1 on the first cycle after it drops.
- `busy` and `tx_ready` are registered and update the cycle after acceptance.
- Line drive changes one cycle after the state or edge decision: `ps2ck` goes low the cycle after acceptance.
- Data changes 3 cycles after the physical device falling edge (2 sync stages plus the register). This is well inside the device's clock-low half-period of at least 30 µs.
- Reset mid-transaction: both lines are Z on the next cycle and no `tx_done` is emitted.
- `tx_done`, `tx_ack_ok` and `tx_error` are high for exactly one cycle per accepted command.

## Structure
- `ps2_pkg` holds:
  - the FSM state enum;
  - default timing constants;
  - command constants `CMD_RESET`=8'hFF, `CMD_ENABLE`=8'hF4, `CMD_SET_RATE`=8'hF3, `RESP_ACK`=8'hFA.
- Sub-module `ps2_line_sync`: 2-FF synchronizer plus falling-edge detector, shared with the receive path.

## Test plan
- **Send 0xF4**, device model with 40 µs half-period that ACKs:
  - `ps2ck` low for exactly 6000 cycles, then 1 cycle with both lines low.
  - Device samples start 0, then data 0,0,1,0,1,1,1,1, then parity 0, then stop 1.
  - `tx_done` pulses with `tx_ack_ok`=1.
- **Send 0xFF**: parity bit sampled 1, and `tx_ack_ok`=1.
- **Device never clocks**: `tx_done` with `tx_error`=1 exactly `REQ_TIMEOUT` cycles after REQ entry; both lines Z; `tx_ready`=1 on the next cycle.
- **Device returns ACK bit high (NACK)**: `tx_done` with `tx_error`=1 and `tx_ack_ok`=0.
- **`reset` asserted during data bit 4**: both lines Z on the next cycle, no `tx_done`. After `reset` drops, a fresh 0xF3 completes with `tx_ack_ok`=1.
- **`tx_valid` held high through a transaction**: the second command is accepted only on the cycle after `tx_done`, with exactly one `tx_done` per command.
